imm_extend_pipe: RTL

//  Parametrised, pipelined immediate-extension stage for the CPU datapath.

---
 rtl/imm_extend_pipe_pkg.sv | 16 +
 rtl/imm_ext_core.sv | 59 +++++
 rtl/imm_extend_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared constants for the immediate-extension stage: mode codes and the
// FSM state encoding (state value = number of held entries).
package imm_extend_pipe_pkg;

  localparam logic [1:0] IMM_SIGN  = 2'b00;
  localparam logic [1:0] IMM_ZERO  = 2'b01;
  localparam logic [1:0] IMM_UPPER = 2'b10;
  localparam logic [1:0] IMM_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: SIGN / ZERO / UPPER / SHIFT mode mux.
// Optional macro IMM_EXT_OVF_EN adds the shift-overflow output ovf_o.
// Width casts are used instead of replications so IN_W == OUT_W still
// elaborates (no zero-width replication).
module imm_ext_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int SHIFT_AMT = 2
) (
  input  logic [1:0]       mode_i,
  input  logic [IN_W-1:0]  data_i,
  output logic [OUT_W-1:0] data_o
`ifdef IMM_EXT_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int PAD_W = OUT_W - IN_W;

  logic signed [IN_W-1:0] din_s;
  logic [OUT_W-1:0]       sext;
  logic [OUT_W-1:0]       zext;
  logic [OUT_W-1:0]       upper;
  logic [OUT_W-1:0]       shifted;

  // Build every candidate result, then select by mode.
  always_comb begin
    din_s   = data_i;
    sext    = OUT_W'(din_s);
    zext    = OUT_W'(data_i);
    upper   = zext << PAD_W;
    shifted = sext << SHIFT_AMT;
    case (mode_i)
      IMM_SIGN:  data_o = sext;
      IMM_ZERO:  data_o = zext;
      IMM_UPPER: data_o = upper;
      default:   data_o = shifted;
    endcase
  end

`ifdef IMM_EXT_OVF_EN
  localparam int WIDE_W = OUT_W + SHIFT_AMT;

  logic signed [WIDE_W-1:0] wide;
  logic signed [WIDE_W-1:0] res_ext;

  // Overflow: the untruncated shift differs from the truncated result
  // re-sign-extended, i.e. some dropped bit differs from the result MSB.
  always_comb begin
    wide    = WIDE_W'(din_s) << SHIFT_AMT;
    res_ext = WIDE_W'(signed'(shifted));
    ovf_o   = (mode_i == IMM_SHIFT) && (wide != res_ext);
  end
`endif

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage: valid/ready handshake, output
// register plus one skid entry so back-pressure never drops an immediate.
// Optional macro IMM_EXT_OVF_EN stores a per-entry shift-overflow flag.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int SHIFT_AMT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       mode_i,
  input  logic [IN_W-1:0]  data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic             ovf_o
);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [OUT_W-1:0] skid_q, skid_d;
  logic [OUT_W-1:0] core_data;
  logic             in_xfer;
  logic             out_xfer;

`ifdef IMM_EXT_OVF_EN
  logic ovf_q, ovf_d;
  logic skid_ovf_q, skid_ovf_d;
  logic core_ovf;
`endif

  imm_ext_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .SHIFT_AMT(SHIFT_AMT)
  ) u_core (
    .mode_i(mode_i),
    .data_i(data_i),
    .data_o(core_data)
`ifdef IMM_EXT_OVF_EN
    ,
    .ovf_o (core_ovf)
`endif
  );

  assign in_xfer  = valid_i & ready_q;
  assign out_xfer = valid_q & ready_i;

  // Next-state, output-register and skid-register update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
`ifdef IMM_EXT_OVF_EN
    ovf_d      = ovf_q;
    skid_ovf_d = skid_ovf_q;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          data_d  = core_data;
`ifdef IMM_EXT_OVF_EN
          ovf_d   = core_ovf;
`endif
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_xfer && out_xfer) begin
          data_d = core_data;
`ifdef IMM_EXT_OVF_EN
          ovf_d  = core_ovf;
`endif
        end else if (in_xfer) begin
          skid_d     = core_data;
`ifdef IMM_EXT_OVF_EN
          skid_ovf_d = core_ovf;
`endif
          state_d    = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          data_d  = skid_q;
`ifdef IMM_EXT_OVF_EN
          ovf_d   = skid_ovf_q;
`endif
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_FULL);
  end

  // State and data registers; reset discards both held entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
      skid_q  <= '0;
`ifdef IMM_EXT_OVF_EN
      ovf_q      <= 1'b0;
      skid_ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
`ifdef IMM_EXT_OVF_EN
      ovf_q      <= ovf_d;
      skid_ovf_q <= skid_ovf_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign data_o  = data_q;
`ifdef IMM_EXT_OVF_EN
  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule
